bf16_dot_sequencer: RTL



---
 rtl/bf16_pkg.sv | 26 ++
 rtl/bf16_pair_fifo.sv | 56 +++++
 rtl/bf16_dot_sequencer.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/bf16_pkg.sv
// Shared definitions for the bfloat16 dot-product sequencer: bf16 constants,
// operand-pair layout and the sequencer state encoding.
package bf16_pkg;

  localparam int          BF16_W    = 16;
  localparam logic [15:0] BF16_QNAN = 16'h7FC0;
  localparam logic [15:0] BF16_ZERO = 16'h0000;

  // One FIFO entry: row operand, column operand, end-of-dot-product flag
  localparam int PAIR_W = 2 * BF16_W + 1;

  typedef struct packed {
    logic [BF16_W-1:0] a;
    logic [BF16_W-1:0] b;
    logic              last;
  } pair_t;

  typedef enum logic [2:0] {
    ST_CLEAR  = 3'd0,
    ST_FETCH  = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RESULT = 3'd4
  } seq_state_t;

endpackage

// File: rtl/bf16_pair_fifo.sv
// Synchronous operand-pair FIFO (a, b, last). DEPTH must be a power of 2 so
// the pointers wrap naturally; full/empty come straight from the registered
// occupancy count. Push while full and pop while empty are ignored.
module bf16_pair_fifo
  import bf16_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [PAIR_W-1:0] wdata,
  input  logic              pop,
  output logic [PAIR_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [PAIR_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; simultaneous push/pop keeps count
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/bf16_dot_sequencer.sv
// Upstream sequencer for a single bf16 multiply-accumulate PE. Buffers operand
// pairs, issues them one at a time (load strobe, wait for done), returns the
// accumulated result on the pair flagged in_last, then clears the PE.
// Optional build macro BF16_SEQ_WATCHDOG_EN adds a WAIT timeout with a sticky
// wdog_err output; a timed-out dot product returns qNaN and its unissued
// pairs are discarded.
module bf16_dot_sequencer
  import bf16_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int CNT_W       = 8,
  parameter int CLR_CYCLES  = 2,
  parameter int WDOG_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_a,
  input  logic [15:0]       in_b,
  input  logic              in_last,
  output logic              pe_load_in,
  output logic [15:0]       pe_row_in,
  output logic [15:0]       pe_col_in,
  output logic              pe_clr,
  input  logic              pe_done_in,
  input  logic [15:0]       pe_result_in,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [15:0]       res_data,
  output logic [CNT_W-1:0]  res_count,
`ifdef BF16_SEQ_WATCHDOG_EN
  output logic              wdog_err,
`endif
  output logic              busy
);

  localparam int CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYCLES - 1);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2 and at least 2");
  end
  if (CLR_CYCLES < 1) begin : g_bad_clr
    $error("CLR_CYCLES must be at least 1");
  end
  if (WDOG_CYCLES < 1) begin : g_bad_wdog
    $error("WDOG_CYCLES must be at least 1");
  end

  seq_state_t        state;
  logic [CLR_W-1:0]  clr_cnt;
  logic [CNT_W-1:0]  pair_cnt;
  logic              last_q;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic              fifo_pop;
  logic [PAIR_W-1:0] fifo_rdata;
  pair_t             head;
  logic              wd_expired;
  logic              drain_q;

  // Saturating increment: the pair counter sticks at all-ones
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // in_ready is forced low while rst is asserted so nothing is accepted
  assign in_ready  = ~fifo_full & ~rst;
  assign fifo_push = in_valid & in_ready;
  assign fifo_pop  = (state == ST_FETCH) & ~fifo_empty;
  assign head      = pair_t'(fifo_rdata);

  bf16_pair_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata ({in_a, in_b, in_last}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef BF16_SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;

  assign wd_expired = (state == ST_WAIT) & ~pe_done_in &
                      (wd_cnt == WD_W'(WDOG_CYCLES - 1));

  // WAIT timeout counter, sticky error flag, and drop of the abandoned tail
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt   <= '0;
      wdog_err <= 1'b0;
      drain_q  <= 1'b0;
    end else begin
      if (state == ST_WAIT && !pe_done_in && !wd_expired) wd_cnt <= wd_cnt + 1'b1;
      else                                                wd_cnt <= '0;
      if (wd_expired) begin
        wdog_err <= 1'b1;
        // If the stalled pair was itself the last one there is nothing to drop
        if (!last_q) drain_q <= 1'b1;
      end else if (fifo_pop && drain_q && head.last) begin
        drain_q <= 1'b0;
      end
    end
  end
`else
  assign wd_expired = 1'b0;
  assign drain_q    = 1'b0;
`endif

  // Sequencer FSM with registered PE handshake and result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_CLEAR;
      clr_cnt    <= '0;
      pe_clr     <= 1'b1;
      pe_load_in <= 1'b0;
      pe_row_in  <= BF16_ZERO;
      pe_col_in  <= BF16_ZERO;
      last_q     <= 1'b0;
      pair_cnt   <= '0;
      res_valid  <= 1'b0;
      res_data   <= BF16_ZERO;
      res_count  <= '0;
      busy       <= 1'b1;
    end else begin
      case (state)
        ST_CLEAR: begin
          if (clr_cnt == CLR_LAST) begin
            clr_cnt <= '0;
            pe_clr  <= 1'b0;
            busy    <= 1'b0;
            state   <= ST_FETCH;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        ST_FETCH: begin
          // While draining, popped pairs are discarded and we stay in FETCH
          if (!fifo_empty && !drain_q) begin
            pe_row_in  <= head.a;
            pe_col_in  <= head.b;
            last_q     <= head.last;
            pe_load_in <= 1'b1;
            busy       <= 1'b1;
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          pe_load_in <= 1'b0;
          state      <= ST_WAIT;
        end
        ST_WAIT: begin
          if (pe_done_in) begin
            pair_cnt <= sat_inc(pair_cnt);
            if (last_q) begin
              res_data  <= pe_result_in;
              res_count <= sat_inc(pair_cnt);
              res_valid <= 1'b1;
              state     <= ST_RESULT;
            end else begin
              busy  <= 1'b0;
              state <= ST_FETCH;
            end
          end else if (wd_expired) begin
            res_data  <= BF16_QNAN;
            res_count <= pair_cnt;
            res_valid <= 1'b1;
            state     <= ST_RESULT;
          end
        end
        ST_RESULT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            pair_cnt  <= '0;
            pe_clr    <= 1'b1;
            clr_cnt   <= '0;
            state     <= ST_CLEAR;
          end
        end
        default: begin
          pe_clr  <= 1'b1;
          clr_cnt <= '0;
          busy    <= 1'b1;
          state   <= ST_CLEAR;
        end
      endcase
    end
  end

endmodule
